// File: rtl/interrupt_sequencer_if.sv
// Data-memory port borrowed by the interrupt sequencer.
// A transfer completes at the rising edge where req & gnt; read data is
// returned on rdata in the cycle after that edge.
//   master: drives req/we/addr/wdata, receives gnt/rdata (the sequencer)
//   slave : the memory side
interface interrupt_sequencer_if #(
    parameter int unsigned W    = 16,
    parameter int unsigned PC_W = 32
) ();
    logic            req;
    logic            gnt;
    logic            we;
    logic [PC_W-1:0] addr;
    logic [W-1:0]    wdata;
    logic [W-1:0]    rdata;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  gnt,
        input  rdata
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output gnt,
        output rdata
    );
endinterface

// File: rtl/interrupt_sequencer.sv
// Interrupt entry / return-from-interrupt sequencer for the 5-stage pipeline.
// Entry: drain in-flight instructions, push resume PC (hi, lo) and flags onto
// the data stack, fetch the 32-bit handler vector, redirect the PC.
// RTI: drain, pop flags, PC lo, PC hi, then restore PC and flags together.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   interrupt_i            interrupt request (latched into a pending bit)
//   irq_safe_i             no branch/jump in flight; gates interrupt entry
//   ret_req_i              RTI decoded this cycle (honoured only when idle)
//   epc_i, flags_in_i      resume PC and current flags to save
//   sp_i                   current stack pointer
//   sp_dec_o, sp_inc_o     one-cycle SP adjust pulses (grant cycle)
//   mem_io                 borrowed data-memory port (req/gnt handshake)
//   stall_fetch_o, flush_o fetch hold and IF/ID NOP injection
//   pc_load_o, pc_next_o   PC redirect strobe and target
//   flags_load_o, flags_out_o  flag restore strobe and value
//   irq_ack_o              handler entered
//   busy_o                 sequencer not idle
module interrupt_sequencer #(
    parameter int unsigned    W            = 16,
    parameter int unsigned    PC_W         = 32,
    parameter int unsigned    FLAG_W       = 3,
    parameter int unsigned    DRAIN_CYCLES = 3,
    parameter logic [PC_W-1:0] VEC_ADDR    = 'h2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 interrupt_i,
    input  logic                 irq_safe_i,
    input  logic                 ret_req_i,
    input  logic [PC_W-1:0]      epc_i,
    input  logic [FLAG_W-1:0]    flags_in_i,
    input  logic [PC_W-1:0]      sp_i,
    output logic                 sp_dec_o,
    output logic                 sp_inc_o,
    interrupt_sequencer_if.master mem_io,
    output logic                 stall_fetch_o,
    output logic                 flush_o,
    output logic                 pc_load_o,
    output logic [PC_W-1:0]      pc_next_o,
    output logic                 flags_load_o,
    output logic [FLAG_W-1:0]    flags_out_o,
    output logic                 irq_ack_o,
    output logic                 busy_o
);

    localparam int unsigned    CntW      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CntW-1:0] CntInit  = CntW'(DRAIN_CYCLES - 1);
    localparam logic [PC_W-1:0] VecAddrHi = VEC_ADDR + PC_W'(1);

    typedef enum logic [4:0] {
        StIdle,
        StDrain,
        StPushHi,
        StPushLo,
        StPushFl,
        StVecLo,
        StVecLoW,
        StVecHi,
        StVecHiW,
        StJump,
        StPopFl,
        StPopFlW,
        StPopLo,
        StPopLoW,
        StPopHi,
        StPopHiW,
        StRet
    } state_e;

    state_e              state_q;
    logic                mode_ret_q;   // 1: current sequence is an RTI
    logic                pending_q;
    logic [CntW-1:0]     cnt_q;
    logic [PC_W-1:0]     epc_q;
    logic [FLAG_W-1:0]   flags_q;      // flags to push
    logic [PC_W-1:0]     pc_next_q;
    logic [FLAG_W-1:0]   flags_out_q;

    logic                mem_req;
    logic                mem_we;
    logic [PC_W-1:0]     mem_addr;
    logic [W-1:0]        mem_wdata;
    logic                xfer;

    assign xfer = mem_io.gnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            mode_ret_q  <= 1'b0;
            pending_q   <= 1'b0;
            cnt_q       <= '0;
            epc_q       <= '0;
            flags_q     <= '0;
            pc_next_q   <= '0;
            flags_out_q <= '0;
        end else begin
            // Any sampled request sets pending; later pulses merge into it.
            if (interrupt_i) begin
                pending_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    // RTI has priority; a tied interrupt stays pending.
                    if (ret_req_i) begin
                        state_q    <= StDrain;
                        mode_ret_q <= 1'b1;
                        cnt_q      <= CntInit;
                    end else if ((pending_q || interrupt_i) && irq_safe_i) begin
                        state_q    <= StDrain;
                        mode_ret_q <= 1'b0;
                        cnt_q      <= CntInit;
                        epc_q      <= epc_i;
                        pending_q  <= 1'b0;
                    end
                end
                StDrain: begin
                    if (cnt_q == '0) begin
                        // Sampled last so retiring instructions' flag updates are kept.
                        flags_q <= flags_in_i;
                        state_q <= mode_ret_q ? StPopFl : StPushHi;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                StPushHi: if (xfer) state_q <= StPushLo;
                StPushLo: if (xfer) state_q <= StPushFl;
                StPushFl: if (xfer) state_q <= StVecLo;
                StVecLo:  if (xfer) state_q <= StVecLoW;
                StVecLoW: begin
                    pc_next_q[W-1:0] <= mem_io.rdata;
                    state_q          <= StVecHi;
                end
                StVecHi:  if (xfer) state_q <= StVecHiW;
                StVecHiW: begin
                    pc_next_q[PC_W-1:W] <= mem_io.rdata;
                    state_q             <= StJump;
                end
                StJump:   state_q <= StIdle;
                StPopFl:  if (xfer) state_q <= StPopFlW;
                StPopFlW: begin
                    flags_out_q <= mem_io.rdata[FLAG_W-1:0];
                    state_q     <= StPopLo;
                end
                StPopLo:  if (xfer) state_q <= StPopLoW;
                StPopLoW: begin
                    pc_next_q[W-1:0] <= mem_io.rdata;
                    state_q          <= StPopHi;
                end
                StPopHi:  if (xfer) state_q <= StPopHiW;
                StPopHiW: begin
                    pc_next_q[PC_W-1:W] <= mem_io.rdata;
                    state_q             <= StRet;
                end
                StRet:    state_q <= StIdle;
                default:  state_q <= StIdle;
            endcase
        end
    end

    // Memory request and strobes decode straight from the state so an
    // asynchronous reset drops them without waiting for an edge.
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        sp_dec_o     = 1'b0;
        sp_inc_o     = 1'b0;
        pc_load_o    = 1'b0;
        irq_ack_o    = 1'b0;
        flags_load_o = 1'b0;
        unique case (state_q)
            StPushHi: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = sp_i;
                mem_wdata = epc_q[PC_W-1:W];
                sp_dec_o  = xfer;
            end
            StPushLo: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = sp_i;
                mem_wdata = epc_q[W-1:0];
                sp_dec_o  = xfer;
            end
            StPushFl: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = sp_i;
                mem_wdata = {{(W-FLAG_W){1'b0}}, flags_q};
                sp_dec_o  = xfer;
            end
            StVecLo: begin
                mem_req  = 1'b1;
                mem_addr = VEC_ADDR;
            end
            StVecHi: begin
                mem_req  = 1'b1;
                mem_addr = VecAddrHi;
            end
            StPopFl, StPopLo, StPopHi: begin
                mem_req  = 1'b1;
                mem_addr = sp_i + PC_W'(1);
                sp_inc_o = xfer;
            end
            StJump: begin
                pc_load_o = 1'b1;
                irq_ack_o = 1'b1;
            end
            StRet: begin
                pc_load_o    = 1'b1;
                flags_load_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign mem_io.req    = mem_req;
    assign mem_io.we     = mem_we;
    assign mem_io.addr   = mem_addr;
    assign mem_io.wdata  = mem_wdata;

    assign busy_o        = (state_q != StIdle);
    assign stall_fetch_o = busy_o;
    assign flush_o       = (state_q == StDrain);
    assign pc_next_o     = pc_next_q;
    assign flags_out_o   = flags_out_q;

endmodule

// File: doc/interrupt_sequencer.md
# interrupt_sequencer

Multi-cycle controller that takes the 16-bit five-stage pipeline through hardware interrupt entry and return-from-interrupt (RTI).
- On interrupt entry it:
  - drains the in-flight instructions;
  - pushes the 32-bit resume PC and the 3-bit flags onto the data-memory stack as 16-bit words;
  - fetches a 32-bit handler vector from fixed memory words;
  - redirects the PC.
- On RTI it pops the same frame and restores PC and flags.
- It sits beside fetch/decode. It owns the fetch stall/flush controls and borrows the data-memory port through a req/gnt handshake.

## Interface
Parameters:
- W, 16: data/memory word width.
- PC_W, 32: PC and address width.
- FLAG_W, 3: flags width.
- DRAIN_CYCLES, 3: cycles of NOP injection before the stack is touched (min 1).
- VEC_ADDR, 32'h0000_0002: address of vector low word. High word is at VEC_ADDR+1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- interrupt  in  1  external interrupt request, sampled each edge.
- irq_safe  in  1  high when no branch/jump is in flight.
- ret_req  in  1  RTI decoded this cycle.
- epc  in  PC_W  PC to resume at.
- flags_in  in  FLAG_W  current CCR flags.
- sp  in  PC_W  current stack pointer.
- sp_dec / sp_inc  out  1  one-cycle pulses to the SP register.
- mem_req  out  1  memory port request.
- mem_gnt  in  1  grant; transfer completes at the edge where req&gnt.
- mem_we  out  1  1 = write.
- mem_addr  out  PC_W  word address.
- mem_wdata  out  W  write data.
- mem_rdata  in  W  read data, valid the cycle after the granting edge.
- stall_fetch  out  1  hold PC and IF/ID.
- flush  out  1  inject NOP into IF/ID.
- pc_load  out  1  load pc_next into PC.
- pc_next  out  PC_W  redirect target.
- flags_load  out  1  load flags_out into CCR.
- flags_out  out  FLAG_W  restored flags.
- irq_ack  out  1  one-cycle pulse, handler entered.
- busy  out  1  state != IDLE.

## Operation
- Pending latch:
  - `interrupt` sampled high sets `pending`. It is cleared on entering DRAIN for an interrupt.
  - Pulses arriving while `pending` is set or `busy` is high collapse into one.
- States:
  - IDLE, DRAIN.
  - Interrupt entry: PUSH_HI, PUSH_LO, PUSH_FL, VEC_LO, VEC_LO_W, VEC_HI, VEC_HI_W, JUMP.
  - Return: POP_FL, POP_FL_W, POP_LO, POP_LO_W, POP_HI, POP_HI_W, RET.
- IDLE exits:
  - ret_req=1 → DRAIN, mode=RET.
  - Else pending & irq_safe → DRAIN, mode=IRQ; epc is latched at this edge.
  - ret_req wins a tie. The interrupt stays pending and is taken after RET.
  - ret_req outside IDLE is ignored.
- DRAIN:
  - Lasts DRAIN_CYCLES cycles with flush=1.
  - flags_in is latched on the last DRAIN cycle, so older instructions' flag updates are included.
- Push states:
  - mem_we=1, mem_addr=sp.
  - wdata: epc[31:16], then epc[15:0], then zero-extended flags.
  - sp_dec pulses in the grant cycle.
- Vector states:
  - Read VEC_ADDR into pc_next[15:0], then VEC_ADDR+1 into pc_next[31:16].
  - *_W states capture mem_rdata with mem_req=0.
- JUMP: pc_load=1 and irq_ack=1 for one cycle, then IDLE.
- Pop states:
  - Read at mem_addr=sp+1; sp_inc pulses in the grant cycle.
  - Order: flags, lo, hi. Flags are taken from rdata[FLAG_W-1:0].
- RET: pc_load=1 and flags_load=1 for one cycle, then IDLE.
- stall_fetch=1 in every non-IDLE state, including JUMP/RET. Fetch resumes from pc_next the cycle after.
- Address arithmetic (sp+1, VEC_ADDR+1) is mod 2^PC_W.

## Timing
- Reset (rst low, asynchronous):
  - State IDLE; pending=0; pc_next=0; flags_out=0.
  - All strobes/requests 0; mem_addr=0; mem_wdata=0.
  - Reset mid-sequence abandons it immediately with no stack unwind. mem_req drops in the same cycle.
- Handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable while waiting.
  - mem_gnt is ignored when mem_req=0.
  - Each memory state waits indefinitely for gnt.
- Latency with gnt tied high, DRAIN_CYCLES=3:
  - Interrupt sampled at edge 0 → DRAIN cycles 1–3, PUSH 4–6, vector 7–10, pc_load in cycle 11.
  - RTI: ret_req at edge 0 → DRAIN 1–3, pops 4–9, pc_load/flags_load in cycle 10.
- irq_safe low holds the controller in IDLE with pending=1, indefinitely.
- An interrupt during RET/JUMP is serviced after return to IDLE. The minimum gap is 1 IDLE cycle.

## Test plan
- **Reset:** rst low during PUSH_LO with gnt=0 → mem_req, stall_fetch and busy go 0 without waiting for a clock edge. After release, state is IDLE and pending=0.
- **Interrupt entry:**
  - Stimulus: epc=0x0001_2345, flags=3'b101, sp=0x07FF (bench decrements SP on sp_dec), gnt=1, mem[2]=0xBEEF, mem[3]=0x0000.
  - Writes: 0x0001@0x07FF, 0x2345@0x07FE, 0x0005@0x07FD.
  - pc_next=0x0000_BEEF; pc_load and irq_ack in cycle 11.
- **Grant wait:** gnt low for 2 cycles in PUSH_HI → addr/wdata stable and held; pc_load moves to cycle 13.
- **RTI round trip** after entry (sp=0x07FC) → reads 0x07FD, 0x07FE, 0x07FF; pc_next=0x0001_2345, flags_out=3'b101; pc_load and flags_load together in cycle 10.
- **Tie and safe:** interrupt and ret_req in the same cycle → RTI completes first, then the interrupt is entered. With irq_safe=0 for 5 cycles → no DRAIN until irq_safe=1.
- **Collapse:** three interrupt pulses during a busy sequence → exactly one further entry (one irq_ack).
